sram_fifo_reader: RTL and testbench
===================================

Name: sram_fifo_reader

Overview:
- Read-side controller for the SRAM-backed FIFO. It is the counterpart of the write-side register/storage path.
- Pops words from FIFO storage with synchronous 1-cycle read latency and presents them on a valid/ready output stream.
- A 2-entry output buffer absorbs read latency and downstream backpressure, sustaining 1 word/cycle.
- Sits between the FIFO storage/flag logic and the consumer; no storage pointers are kept here.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and output data.
- CNT_WIDTH, 16, width of the popped-word counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- fifo_empty  input  1  FIFO empty flag from storage control; sampled combinationally each cycle.
- fifo_rd_en  output  1  read request to storage; one word is consumed per cycle it is high.
- fifo_rdata  input  DATA_WIDTH  storage read data; valid the cycle after fifo_rd_en.
- m_valid  output  1  output word available.
- m_data  output  DATA_WIDTH  output word (head of buffer).
- m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
- pop_count  output  CNT_WIDTH  number of words delivered on the output stream.

Behaviour:
- Reset (rst==0, asynchronous):
  - fifo_rd_en=0, m_valid=0, m_data=0, pop_count=0.
  - Buffer emptied; in-flight-read flag cleared.
  - A read issued before reset is dropped; its returning data is ignored.
- State:
  - entries: 0..2 words held in the buffer.
  - inflight: 1 when fifo_rd_en was high in the previous cycle.
  - pop = m_valid && m_ready.
- Read issue (combinational from registered state, fifo_empty and pop):
  - fifo_rd_en = !fifo_empty && ((entries+inflight) < 2 || ((entries+inflight)==2 && pop)).
  - Never high while fifo_empty=1, so there is no underflow.
  - entries+inflight never exceeds 2, so the buffer never overflows.
- Data return:
  - If inflight=1, fifo_rdata is captured at that posedge into the tail of the buffer.
  - Word order equals FIFO order.
- Output:
  - m_valid = (entries>0); m_data = buffer head, driven from a register.
  - While m_valid && !m_ready, m_data and m_valid hold stable, unchanged until accepted.
- Simultaneous capture and pop: the head advances and the new word enters. entries stays the same, with no bubble.
- Latency: fifo_empty falls in cycle 0 → fifo_rd_en=1 in cycle 0 → data captured at end of cycle 1 → m_valid=1 in cycle 2.
- Throughput: with fifo_empty=0 and m_ready=1 continuously, steady state is 1 word/cycle. fifo_rd_en stays high and m_valid stays high.
- Backpressure: with m_ready=0, at most 2 reads are issued, then fifo_rd_en=0 until a pop occurs.
  - A pop in a full-credit cycle re-enables fifo_rd_en in that same cycle.
- pop_count:
  - Increments by 1 on each pop.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- fifo_empty rising mid-stream: issuing stops immediately. Buffered and in-flight words still drain normally.

Test Plan:
- Reset/idle: hold rst=0, then release with fifo_empty=1 for 10 cycles → fifo_rd_en=0, m_valid=0, m_data=0, pop_count=0 throughout.
- First-word latency: preload FIFO {0xA5}, drop fifo_empty in cycle 0 (rises after the one read), m_ready=1 → fifo_rd_en high cycle 0 only; m_valid=1 with m_data=0xA5 in cycle 2 only; pop_count=1.
- Streaming: FIFO holds 0x00..0x0F, m_ready=1 → m_valid continuous for 16 cycles starting cycle 2; data 0x00..0x0F in order; pop_count=16; fifo_rd_en high exactly 16 cycles.
- Backpressure: FIFO holds 0x10..0x17, m_ready=0 → exactly 2 fifo_rd_en pulses; m_data=0x10 held stable. Then m_ready=1 → 0x10..0x17 delivered in order with no gap and no duplicates.
- Random backpressure: m_ready 50% random, 256 words from a scoreboarded FIFO → all words in order, fifo_rd_en never high while fifo_empty=1, entries never exceeds 2.
- Reset mid-operation: assert rst during streaming with a read in flight → outputs 0 asynchronously. After release with fifo_empty=1, m_valid stays 0 (the in-flight word is discarded). A pop_count wrap check with CNT_WIDTH=4 and 17 pops gives pop_count=1.

Source files
------------

// File: rtl/sram_fifo_reader.sv
// sram_fifo_reader: read side of the SRAM-backed FIFO.
// Issues reads into storage that has a one-cycle read latency and keeps a
// 2-entry skid buffer so the output stream runs at one word per cycle under
// backpressure. Storage pointers live in the storage/flag logic, not here.
module sram_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  // Buffer occupancy (0..2), read-in-flight flag, head/tail words, counter
  logic [1:0]            r_entries;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_WIDTH-1:0]  r_pop_count;

  logic                  w_pop;
  logic                  w_rd_en;
  logic [1:0]            w_credit;

  // Read issue: keep buffered + in-flight words at or below two. A pop in
  // the same cycle frees a slot, so a full-credit cycle can still issue.
  // Gating with rst keeps the request low for the whole reset interval.
  always_comb begin
    w_pop    = (r_entries != 2'd0) && m_ready;
    w_credit = r_entries + {1'b0, r_inflight};
    w_rd_en  = 1'b0;
    if (rst && !fifo_empty) begin
      if (w_credit < 2'd2) begin
        w_rd_en = 1'b1;
      end else if ((w_credit == 2'd2) && w_pop) begin
        w_rd_en = 1'b1;
      end else begin
        w_rd_en = 1'b0;
      end
    end else begin
      w_rd_en = 1'b0;
    end
  end

  // Buffer update: capture returning read data at the tail, advance the
  // head on a pop; capture and pop together keep occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entries  <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= {DATA_WIDTH{1'b0}};
      r_tail     <= {DATA_WIDTH{1'b0}};
    end else begin
      r_inflight <= w_rd_en;
      case (r_entries)
        2'd0: begin
          if (r_inflight) begin
            r_head    <= fifo_rdata;
            r_entries <= 2'd1;
          end
        end
        2'd1: begin
          case ({r_inflight, w_pop})
            2'b11: r_head <= fifo_rdata;
            2'b01: r_entries <= 2'd0;
            2'b10: begin
              r_tail    <= fifo_rdata;
              r_entries <= 2'd2;
            end
            default: r_entries <= 2'd1;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (r_inflight) begin
              r_tail <= fifo_rdata;
            end else begin
              r_entries <= 2'd1;
            end
          end
        end
        default: r_entries <= 2'd0;
      endcase
    end
  end

  // Delivered-word counter; wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pop_count <= {CNT_WIDTH{1'b0}};
    end else if (w_pop) begin
      r_pop_count <= r_pop_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = (r_entries != 2'd0);
  assign m_data     = r_head;
  assign pop_count  = r_pop_count;

endmodule

// File: tb/tb_sram_fifo_reader.sv
// Scoreboarded bench for sram_fifo_reader: a queue models FIFO storage with
// one-cycle read latency; words are pushed to the expected queue when loaded
// and compared in order whenever the output stream hands one over.
module tb_sram_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rdata;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [15:0] pop_count;

  logic        rd_en4;
  logic        m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  pop_count4;

  int total = 0;
  int bad   = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  bit  hold_empty = 1'b1;
  int  issued = 0;
  int  delivered = 0;

  sram_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .pop_count(pop_count)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check
  sram_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en4),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid4), .m_data(m_data4),
    .m_ready(m_ready), .pop_count(pop_count4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock cycle: drive inputs at negedge, sample after settling, model
  // storage read latency by presenting the popped word after the posedge.
  task automatic cycle(input logic rdy, output logic rd, output logic vld, output logic [7:0] dat);
    logic       pend;
    logic [7:0] pend_data;
    logic [7:0] want;
    @(negedge clk);
    m_ready    = rdy;
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    #1;
    rd  = fifo_rd_en;
    vld = m_valid;
    dat = m_data;
    pend = 1'b0;
    pend_data = 8'h00;
    if (fifo_rd_en) begin
      check_eq("no_underflow", {31'd0, fifo_empty}, 32'd0);
      if (fifo_q.size() != 0) begin
        pend = 1'b1;
        pend_data = fifo_q.pop_front();
      end
      issued++;
    end
    if (m_valid && m_ready) begin
      delivered++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_word", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check_eq("stream_data", {24'd0, m_data}, {24'd0, want});
      end
    end
    if (fifo_rd_en) begin
      check_eq("credit_le2", ((issued - delivered) <= 2) ? 32'd1 : 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    if (pend) fifo_rdata = pend_data;
    else      fifo_rdata = 8'($urandom);
  endtask

  initial begin
    logic       rd;
    logic       vd;
    logic [7:0] dd;
    logic       rda[5];
    logic       vda[5];
    logic [7:0] dda[5];
    int cnt_rd;
    int cnt_vd;
    int first_vd;
    int n;

    rst = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0; fifo_rdata = 8'h00;
    #23;
    check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_data", {24'd0, m_data}, 32'd0);
    check_eq("rst_count", {16'd0, pop_count}, 32'd0);
    rst = 1'b1;

    // Idle with empty FIFO
    hold_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, rd, vd, dd);
      check_eq("idle_rd_en", {31'd0, rd}, 32'd0);
      check_eq("idle_valid", {31'd0, vd}, 32'd0);
      check_eq("idle_data", {24'd0, dd}, 32'd0);
      check_eq("idle_count", {16'd0, pop_count}, 32'd0);
    end

    // First-word latency
    hold_empty = 1'b0;
    load(8'hA5);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rd, vd, dd);
      rda[i] = rd; vda[i] = vd; dda[i] = dd;
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("lat_rd_en", {31'd0, rda[i]}, (i == 0) ? 32'd1 : 32'd0);
      check_eq("lat_valid", {31'd0, vda[i]}, (i == 2) ? 32'd1 : 32'd0);
    end
    check_eq("lat_data", {24'd0, dda[2]}, 32'hA5);
    check_eq("lat_count", {16'd0, pop_count}, 32'd1);

    // Streaming 16 words
    for (int i = 0; i < 16; i++) load(8'(i));
    cnt_rd = 0; cnt_vd = 0; first_vd = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, rd, vd, dd);
      if (rd) cnt_rd++;
      if (vd) begin
        cnt_vd++;
        if (first_vd < 0) first_vd = i;
      end
    end
    check_eq("stream_first_valid", 32'(first_vd), 32'd2);
    check_eq("stream_valid_cycles", 32'(cnt_vd), 32'd16);
    check_eq("stream_rd_cycles", 32'(cnt_rd), 32'd16);
    check_eq("stream_count", {16'd0, pop_count}, 32'd17);

    // Backpressure
    for (int i = 0; i < 8; i++) load(8'h10 + 8'(i));
    cnt_rd = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, rd, vd, dd);
      if (rd) cnt_rd++;
      if (i >= 2) begin
        check_eq("bp_hold_valid", {31'd0, vd}, 32'd1);
        check_eq("bp_hold_data", {24'd0, dd}, 32'h10);
      end
    end
    check_eq("bp_rd_pulses", 32'(cnt_rd), 32'd2);
    cnt_vd = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, rd, vd, dd);
      if (i < 8) check_eq("bp_no_gap", {31'd0, vd}, 32'd1);
      if (vd) cnt_vd++;
    end
    check_eq("bp_delivered", 32'(cnt_vd), 32'd8);
    check_eq("bp_count", {16'd0, pop_count}, 32'd25);

    // Random backpressure and random empty stalls, 256 words
    for (int i = 0; i < 256; i++) load(8'($urandom));
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      hold_empty = ($urandom_range(0, 4) == 0);
      cycle(1'($urandom_range(0, 1)), rd, vd, dd);
      n++;
    end
    hold_empty = 1'b0;
    check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rand_count", {16'd0, pop_count}, 32'd281);

    // Reset with a read in flight
    for (int i = 0; i < 16; i++) load(8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) cycle(1'b1, rd, vd, dd);
    check_eq("mid_inflight", {31'd0, rd}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("mid_valid", {31'd0, m_valid}, 32'd0);
    check_eq("mid_data", {24'd0, m_data}, 32'd0);
    check_eq("mid_count", {16'd0, pop_count}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    issued = 0; delivered = 0;
    hold_empty = 1'b1;
    #20;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, rd, vd, dd);
      check_eq("post_rst_valid", {31'd0, vd}, 32'd0);
    end

    // Counter wrap with the 4-bit instance
    hold_empty = 1'b0;
    for (int i = 0; i < 17; i++) load(8'h50 + 8'(i));
    for (int i = 0; i < 25; i++) cycle(1'b1, rd, vd, dd);
    check_eq("wrap_drained", 32'(exp_q.size()), 32'd0);
    check_eq("wrap_count16", {16'd0, pop_count}, 32'd17);
    check_eq("wrap_count4", {28'd0, pop_count4}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
